mem_arbiter: RTL and testbench

- Shares the single RAM port between NREQ cache-side requesters, e.g. icache/dcache of core 0 and core 1 in the dual-core build.
- Round-robin arbitration, one requester served at a time; a registered grant steers that requester's address/data to RAM.
- Supports burst lock so a multi-word block fill or writeback is not interleaved with other traffic.
- Sits between the caches and the RAM model, in place of the direct cache-to-RAM connection.

---
 rtl/mem_arbiter.sv | 124 ++++++++++++
 tb/tb_mem_arbiter.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - round-robin arbiter sharing one RAM port among NREQ cache requesters, with burst lock
// Optional MEM_ARB_WRITE_PRIORITY_EN: pending writes win IDLE arbitration over reads.

module mem_arbiter #(
  parameter int NREQ      = 4,
  parameter int MAX_BURST = 2
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic [NREQ-1:0]   req_ren,
  input  logic [NREQ-1:0]   req_wen,
  input  logic [NREQ*32-1:0] req_addr,
  input  logic [NREQ*32-1:0] req_store,
  input  logic [NREQ-1:0]   req_burst,
  output logic [NREQ-1:0]   req_wait,
  output logic [31:0]       req_load,
  output logic [NREQ-1:0]   grant,
  output logic              ram_ren,
  output logic              ram_wen,
  output logic [31:0]       ram_addr,
  output logic [31:0]       ram_store,
  input  logic              ram_ready,
  input  logic [31:0]       ram_load
);
  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CW = $clog2(MAX_BURST) + 1;

  typedef enum logic {IDLE, XFER} state_t;

  state_t          state, state_n;
  logic [NREQ-1:0] grant_n;
  logic [PW-1:0]   rr_ptr, rr_ptr_n, g_idx, win_idx;
  logic [CW-1:0]   burst_cnt, burst_cnt_n, burst_inc;
  logic [NREQ-1:0] active, cand;
  logic            win_found;

  assign active    = req_ren | req_wen;
  assign req_load  = ram_load;
  assign burst_inc = burst_cnt + 1'b1;
  assign req_wait  = active & ~(grant & {NREQ{ram_ready && (state == XFER)}});

  always_comb begin
    g_idx = '0;
    for (int i = 0; i < NREQ; i++)
      if (grant[i]) g_idx = PW'(i);
  end

  always_comb begin
    cand = active;
`ifdef MEM_ARB_WRITE_PRIORITY_EN
    if (|req_wen) cand = req_wen;
`endif
  end

  // Scan indices above rr_ptr first, then wrap to the low indices.
  always_comb begin
    win_idx   = '0;
    win_found = 1'b0;
    for (int i = 0; i < NREQ; i++)
      if (!win_found && cand[i] && (PW'(i) > rr_ptr)) begin
        win_found = 1'b1;
        win_idx   = PW'(i);
      end
    for (int i = 0; i < NREQ; i++)
      if (!win_found && cand[i]) begin
        win_found = 1'b1;
        win_idx   = PW'(i);
      end
  end

  always_comb begin
    state_n     = state;
    grant_n     = grant;
    rr_ptr_n    = rr_ptr;
    burst_cnt_n = burst_cnt;
    ram_ren     = 1'b0;
    ram_wen     = 1'b0;
    ram_addr    = '0;
    ram_store   = '0;
    case (state)
      IDLE: begin
        if (win_found) begin
          grant_n     = NREQ'(1) << win_idx;
          burst_cnt_n = '0;
          state_n     = XFER;
        end
      end
      XFER: begin
        ram_addr  = req_addr[g_idx*32 +: 32];
        ram_store = req_store[g_idx*32 +: 32];
        ram_wen   = req_wen[g_idx];
        ram_ren   = req_ren[g_idx] & ~req_wen[g_idx];
        // Completion takes precedence over a same-cycle request drop.
        if (ram_ready) begin
          rr_ptr_n    = g_idx;
          burst_cnt_n = burst_inc;
          if (!(req_burst[g_idx] && (burst_inc < CW'(MAX_BURST)))) begin
            grant_n = '0;
            state_n = IDLE;
          end
        end else if (!active[g_idx]) begin
          grant_n = '0;
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state     <= IDLE;
      grant     <= '0;
      rr_ptr    <= PW'(NREQ - 1);
      burst_cnt <= '0;
    end else begin
      state     <= state_n;
      grant     <= grant_n;
      rr_ptr    <= rr_ptr_n;
      burst_cnt <= burst_cnt_n;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - directed and randomized checks of mem_arbiter against a transaction-level model

module tb_mem_arbiter;
  localparam int N  = 4;
  localparam int MB = 2;
  localparam int PW = 2;

  logic             CLK = 1'b0;
  logic             nRST;
  logic [N-1:0]     req_ren, req_wen, req_burst, req_wait, grant;
  logic [N*32-1:0]  req_addr, req_store;
  logic [31:0]      req_load, ram_addr, ram_store, ram_load;
  logic             ram_ren, ram_wen, ram_ready;

  logic [31:0] a_v [N];
  logic [31:0] s_v [N];
  int n_cmp = 0;
  int n_err = 0;

  // Model: owner is the served requester (-1 = idle), rr is the last completed index.
  int m_owner, m_rr, m_cnt;
  logic [N-1:0] obs_grant;
  logic [31:0]  obs_addr;
  logic         obs_ren, obs_wen;

  mem_arbiter #(.NREQ(N), .MAX_BURST(MB)) dut (
    .CLK(CLK), .nRST(nRST),
    .req_ren(req_ren), .req_wen(req_wen), .req_addr(req_addr), .req_store(req_store),
    .req_burst(req_burst), .req_wait(req_wait), .req_load(req_load), .grant(grant),
    .ram_ren(ram_ren), .ram_wen(ram_wen), .ram_addr(ram_addr), .ram_store(ram_store),
    .ram_ready(ram_ready), .ram_load(ram_load)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic bit_of(input logic [N-1:0] v, input int i);
    return 1'(v >> i);
  endfunction

  function automatic int pick(input logic [N-1:0] ren, input logic [N-1:0] wen);
    logic [N-1:0] c;
    c = ren | wen;
`ifdef MEM_ARB_WRITE_PRIORITY_EN
    if (wen != 0) c = wen;
`endif
    for (int k = 1; k <= N; k++)
      if (bit_of(c, (m_rr + k) % N)) return (m_rr + k) % N;
    return -1;
  endfunction

  task automatic step(input logic [N-1:0] ren, input logic [N-1:0] wen,
                      input logic [N-1:0] burst, input logic rdy);
    logic [N-1:0] e_grant, e_wait;
    logic [31:0]  e_addr, e_store;
    logic         e_ren, e_wen;
    int           w;
    req_ren = ren; req_wen = wen; req_burst = burst; ram_ready = rdy;
    ram_load = $urandom;
    for (int i = 0; i < N; i++) begin
      req_addr[i*32 +: 32]  = a_v[i];
      req_store[i*32 +: 32] = s_v[i];
    end
    @(negedge CLK);
    e_grant = '0; e_ren = 1'b0; e_wen = 1'b0; e_addr = '0; e_store = '0;
    if (m_owner >= 0) begin
      e_grant = N'(1) << m_owner;
      e_wen   = bit_of(wen, m_owner);
      e_ren   = bit_of(ren, m_owner) & ~bit_of(wen, m_owner);
      e_addr  = a_v[PW'(m_owner)];
      e_store = s_v[PW'(m_owner)];
    end
    for (int i = 0; i < N; i++)
      e_wait[i] = (ren[i] | wen[i]) && !(m_owner == i && rdy);
    check("grant", 64'(grant), 64'(e_grant));
    check("req_wait", 64'(req_wait), 64'(e_wait));
    check("ram_ren", 64'(ram_ren), 64'(e_ren));
    check("ram_wen", 64'(ram_wen), 64'(e_wen));
    check("ram_addr", 64'(ram_addr), 64'(e_addr));
    check("ram_store", 64'(ram_store), 64'(e_store));
    check("req_load", 64'(req_load), 64'(ram_load));
    obs_grant = grant; obs_addr = ram_addr; obs_ren = ram_ren; obs_wen = ram_wen;
    @(posedge CLK);
    if (m_owner < 0) begin
      w = pick(ren, wen);
      if (w >= 0) begin
        m_owner = w;
        m_cnt   = 0;
      end
    end else if (rdy) begin
      m_rr = m_owner;
      m_cnt++;
      if (!(bit_of(burst, m_owner) && m_cnt < MB)) m_owner = -1;
    end else if (!(bit_of(ren, m_owner) | bit_of(wen, m_owner))) begin
      m_owner = -1;
    end
    #1;
  endtask

  initial begin
    logic [N-1:0] rn, wn, bu;
    for (int i = 0; i < N; i++) begin
      a_v[i] = 32'h0;
      s_v[i] = 32'h1000 + 32'(i);
    end
    req_ren = '0; req_wen = '0; req_burst = '0; ram_ready = 1'b0; ram_load = 32'h5a5a;
    req_addr = '0; req_store = '0;
    m_owner = -1; m_rr = N - 1; m_cnt = 0;

    nRST = 1'b0;
    #12;
    check("rst_grant", 64'(grant), 64'h0);
    check("rst_ren", 64'(ram_ren), 64'h0);
    check("rst_wen", 64'(ram_wen), 64'h0);
    check("rst_wait", 64'(req_wait), 64'h0);
    check("rst_addr", 64'(ram_addr), 64'h0);
    @(negedge CLK); nRST = 1'b1;
    @(posedge CLK); #1;
    step('0, '0, '0, 1'b0);
    step('0, '0, '0, 1'b1);
    check("idle_after_rst", 64'(obs_grant), 64'h0);

    // Two readers raised together are served in index order.
    a_v[0] = 32'h100; a_v[2] = 32'h200;
    step(4'b0101, '0, '0, 1'b0);
    step(4'b0101, '0, '0, 1'b1);
    check("rr_first_grant", 64'(obs_grant), 64'b0001);
    check("rr_first_addr", 64'(obs_addr), 64'h100);
    step(4'b0100, '0, '0, 1'b0);
    step(4'b0100, '0, '0, 1'b0);
    check("rr_second_grant", 64'(obs_grant), 64'b0100);
    check("rr_second_addr", 64'(obs_addr), 64'h200);
    step(4'b0100, '0, '0, 1'b1);
    step('0, '0, '0, 1'b0);
    check("rr_idle", 64'(obs_grant), 64'h0);

    // Abort: requester 0 drops before ready, then wins again alone.
    step(4'b0001, '0, '0, 1'b0);
    step(4'b0000, '0, '0, 1'b0);
    check("abort_grant", 64'(obs_grant), 64'b0001);
    check("abort_strobe", 64'(obs_ren), 64'h0);
    step(4'b0001, '0, '0, 1'b0);
    check("abort_idle", 64'(obs_grant), 64'h0);
    step(4'b0001, '0, '0, 1'b1);
    check("abort_regrant", 64'(obs_grant), 64'b0001);
    step('0, '0, '0, 1'b0);

    // Locked burst write from requester 1 while requester 3 waits.
    a_v[1] = 32'h40; a_v[3] = 32'h300;
    step(4'b1000, 4'b0010, 4'b0010, 1'b0);
    step(4'b1000, 4'b0010, 4'b0010, 1'b1);
    check("burst_w1_grant", 64'(obs_grant), 64'b0010);
    check("burst_w1_addr", 64'(obs_addr), 64'h40);
    check("burst_w1_wen", 64'(obs_wen), 64'h1);
    a_v[1] = 32'h44;
    step(4'b1000, 4'b0010, 4'b0010, 1'b1);
    check("burst_w2_grant", 64'(obs_grant), 64'b0010);
    check("burst_w2_addr", 64'(obs_addr), 64'h44);
    step(4'b1000, 4'b0000, 4'b0000, 1'b0);
    step(4'b1000, 4'b0000, 4'b0000, 1'b1);
    check("burst_then_r3", 64'(obs_grant), 64'b1000);
    step('0, '0, '0, 1'b0);

    // Burst held beyond MAX_BURST: forced release, requester 2 gets the next round.
    step(4'b0100, 4'b0010, 4'b0010, 1'b0);
    step(4'b0100, 4'b0010, 4'b0010, 1'b1);
    step(4'b0100, 4'b0010, 4'b0010, 1'b1);
    check("force_w2_grant", 64'(obs_grant), 64'b0010);
    step(4'b0100, 4'b0010, 4'b0010, 1'b0);
    check("force_release", 64'(obs_grant), 64'h0);
    step(4'b0100, 4'b0010, 4'b0010, 1'b1);
    check("force_next", 64'(obs_grant), 64'b0100);
    step(4'b0000, 4'b0010, 4'b0010, 1'b0);
    step(4'b0000, 4'b0010, 4'b0000, 1'b1);
    check("force_regrant", 64'(obs_grant), 64'b0010);
    step('0, '0, '0, 1'b0);

    // Reset in the middle of a transfer drops strobes without a clock edge.
    step(4'b0001, '0, '0, 1'b0);
    step(4'b0001, '0, '0, 1'b0);
    #2 nRST = 1'b0;
    #1;
    check("midrst_ren", 64'(ram_ren), 64'h0);
    check("midrst_grant", 64'(grant), 64'h0);
    check("midrst_wait", 64'(req_wait), 64'b0001);
    req_ren = '0;
    @(negedge CLK); nRST = 1'b1;
    m_owner = -1; m_rr = N - 1; m_cnt = 0;
    @(posedge CLK); #1;

    // Simultaneous read 0 and write 3 straight after reset.
    step(4'b0001, 4'b1000, '0, 1'b0);
    step(4'b0001, 4'b1000, '0, 1'b1);
`ifdef MEM_ARB_WRITE_PRIORITY_EN
    check("prio_first", 64'(obs_grant), 64'b1000);
`else
    check("prio_first", 64'(obs_grant), 64'b0001);
`endif
    step('0, '0, '0, 1'b0);

    rn = '0; wn = '0; bu = '0;
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < N; i++)
        if ($urandom_range(3) == 0) begin
          rn[i]  = ($urandom_range(2) == 0);
          wn[i]  = ($urandom_range(3) == 0);
          bu[i]  = 1'($urandom);
          a_v[i] = $urandom;
          s_v[i] = $urandom;
        end
      step(rn, wn, bu, 1'($urandom));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
